// File: rtl/deser_arbiter.sv
// deser_arbiter: round-robin arbiter sharing one deserializer between
// CHANNELS serial sources, one DATA_BUS_WIDTH-bit word per grant.
// Optional feature: define DESER_ARB_WATCHDOG_EN to add a stall watchdog
// that aborts a word after TIMEOUT_CYCLES consecutive idle cycles.
`timescale 1ns/1ps

module deser_arbiter #(
  parameter int CHANNELS       = 4,
  parameter int DATA_BUS_WIDTH = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                          clk_i,
  input  logic                          arst_n_i,
  input  logic [CHANNELS-1:0]           req_i,
  input  logic [CHANNELS-1:0]           data_i,
  input  logic [CHANNELS-1:0]           data_val_i,
  output logic [CHANNELS-1:0]           gnt_o,
  output logic                          busy_o,
  output logic                          ser_data_o,
  output logic                          ser_data_val_o,
  output logic                          deser_srst_o,
  output logic [$clog2(CHANNELS)-1:0]   word_ch_o,
  output logic                          word_ch_val_o,
  output logic                          abort_o
);

  localparam int CW   = $clog2(CHANNELS);
  localparam int CNTW = $clog2(DATA_BUS_WIDTH) + 1;

  // Elaboration-time sanity checks on the configuration
  if (CHANNELS < 2) begin : g_bad_channels
    $error("deser_arbiter: CHANNELS must be at least 2");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("deser_arbiter: TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic {
    IDLE,
    XFER
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [CHANNELS-1:0] gnt;
  logic [CHANNELS-1:0] gnt_nxt;
  logic [CW-1:0]       gnt_idx;
  logic [CW-1:0]       gnt_idx_nxt;
  logic [CW-1:0]       ptr;
  logic [CW-1:0]       ptr_nxt;
  logic [CNTW-1:0]     cnt;
  logic [CNTW-1:0]     cnt_nxt;
  logic [CW-1:0]       word_ch;
  logic [CW-1:0]       word_ch_nxt;
  logic                word_ch_val;
  logic                word_ch_val_nxt;
  logic                deser_srst;
  logic                deser_srst_nxt;
  logic                do_grant;

  logic [CHANNELS-1:0] req_eff;
  logic                win_found;
  logic [CW-1:0]       win_idx;
  logic [CW:0]         cand;

  logic                cur_val;
  logic                timeout;

  // The granted channel's own request is ignored while it holds the grant,
  // which also gives it lowest priority at re-arbitration.
  assign req_eff = req_i & ~gnt;
  assign cur_val = data_val_i[gnt_idx];

  // Round-robin search: first requester at or after ptr, wrapping around
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      cand = {1'b0, ptr} + (CW+1)'(i);
      if (cand >= (CW+1)'(CHANNELS)) begin
        cand = cand - (CW+1)'(CHANNELS);
      end
      if (!win_found && req_eff[cand[CW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[CW-1:0];
      end
    end
  end

  // Next-state logic: grant, bit counting, word completion and abort
  always_comb begin
    state_nxt       = state;
    gnt_nxt         = gnt;
    gnt_idx_nxt     = gnt_idx;
    ptr_nxt         = ptr;
    cnt_nxt         = cnt;
    word_ch_nxt     = word_ch;
    word_ch_val_nxt = 1'b0;
    deser_srst_nxt  = 1'b0;
    do_grant        = 1'b0;

    case (state)
      IDLE: begin
        if (win_found) begin
          do_grant = 1'b1;
        end
      end
      XFER: begin
        if (cur_val) begin
          if (cnt == CNTW'(DATA_BUS_WIDTH - 1)) begin
            cnt_nxt         = '0;
            word_ch_nxt     = gnt_idx;
            word_ch_val_nxt = 1'b1;
            if (win_found) begin
              do_grant = 1'b1;
            end else begin
              gnt_nxt   = '0;
              state_nxt = IDLE;
            end
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end else if (timeout) begin
          gnt_nxt        = '0;
          cnt_nxt        = '0;
          state_nxt      = IDLE;
          deser_srst_nxt = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
      end
    endcase

    if (do_grant) begin
      state_nxt   = XFER;
      gnt_nxt     = CHANNELS'(1) << win_idx;
      gnt_idx_nxt = win_idx;
      ptr_nxt     = (win_idx == CW'(CHANNELS - 1)) ? '0 : win_idx + 1'b1;
    end
  end

  // State register; deser_srst sits high in reset to flush the deserializer
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state       <= IDLE;
      gnt         <= '0;
      gnt_idx     <= '0;
      ptr         <= '0;
      cnt         <= '0;
      word_ch     <= '0;
      word_ch_val <= 1'b0;
      deser_srst  <= 1'b1;
    end else begin
      state       <= state_nxt;
      gnt         <= gnt_nxt;
      gnt_idx     <= gnt_idx_nxt;
      ptr         <= ptr_nxt;
      cnt         <= cnt_nxt;
      word_ch     <= word_ch_nxt;
      word_ch_val <= word_ch_val_nxt;
      deser_srst  <= deser_srst_nxt;
    end
  end

`ifdef DESER_ARB_WATCHDOG_EN
  localparam int SW = $clog2(TIMEOUT_CYCLES + 1);

  logic [SW-1:0] stall;
  logic          abort;

  // This edge is the TIMEOUT_CYCLES-th consecutive stalled cycle
  assign timeout = (state == XFER) && !cur_val &&
                   (stall == SW'(TIMEOUT_CYCLES - 1));

  // Stall counter: clears on any valid bit or outside a transfer
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      stall <= '0;
    end else if ((state != XFER) || cur_val || timeout) begin
      stall <= '0;
    end else begin
      stall <= stall + 1'b1;
    end
  end

  // One-cycle abort pulse registered on the timeout edge
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      abort <= 1'b0;
    end else begin
      abort <= timeout;
    end
  end

  assign abort_o = abort;
`else
  assign timeout = 1'b0;
  assign abort_o = 1'b0;
`endif

  assign gnt_o          = gnt;
  assign busy_o         = |gnt;
  assign ser_data_o     = busy_o ? data_i[gnt_idx] : 1'b0;
  assign ser_data_val_o = cur_val & busy_o;
  assign deser_srst_o   = deser_srst;
  assign word_ch_o      = word_ch;
  assign word_ch_val_o  = word_ch_val;

endmodule

// File: doc/deser_arbiter.md
# deser_arbiter

Round-robin arbiter that shares one `deserializer` instance between `CHANNELS` serial sources. Each source requests the deserializer for exactly one `DATA_BUS_WIDTH`-bit word. The arbiter grants one source at a time, muxes that source's bit stream onto the deserializer input, and emits the winning channel number aligned with the deserializer's parallel-word valid. It also owns the deserializer's synchronous reset so it can flush a partial word.

## Interface
- `CHANNELS`, 4: number of serial sources; ≥2.
- `DATA_BUS_WIDTH`, 16: bits per word; must equal the deserializer's `DATA_BUS_WIDTH`.
- `TIMEOUT_CYCLES`, 64: stall limit in cycles; used only with the watchdog (see Configuration).
- `clk_i`, in, 1: single clock.
- `arst_n_i`, in, 1: reset, asynchronous, active-low.
- `req_i`, in, `CHANNELS`: per-channel word request; level, held until granted.
- `data_i`, in, `CHANNELS`: per-channel serial bit.
- `data_val_i`, in, `CHANNELS`: per-channel bit valid.
- `gnt_o`, out, `CHANNELS`: one-hot grant, registered.
- `busy_o`, out, 1: a word transfer is in progress (`|gnt_o`).
- `ser_data_o`, out, 1: to deserializer `data_i`; equals `data_i[g]`, or 0 when idle.
- `ser_data_val_o`, out, 1: to deserializer `data_val_i`; equals `data_val_i[g] & busy_o`.
- `deser_srst_o`, out, 1: to deserializer `srst_i`; registered.
- `word_ch_o`, out, `$clog2(CHANNELS)`: channel that produced the current deserializer word.
- `word_ch_val_o`, out, 1: one-cycle pulse coincident with the deserializer's `deser_data_val_o`.
- `abort_o`, out, 1: one-cycle pulse when a word is aborted (watchdog only; tied 0 otherwise).

## Operation
- FSM states:
  - `IDLE`: `gnt_o == 0`. If any `req_i` bit is high, register a grant to the winner and go to `XFER`.
  - `XFER`: one channel `g` is granted. Each cycle with `data_val_i[g]` high increments the bit counter, which is `$clog2(DATA_BUS_WIDTH)+1` bits wide and wraps to 0 after `DATA_BUS_WIDTH-1`.
- The last bit is the edge where `data_val_i[g] && cnt == DATA_BUS_WIDTH-1`. On that edge:
  - `word_ch_o <= g`.
  - `word_ch_val_o <= 1`.
  - `cnt <= 0`.
  - The grant is re-arbitrated. If another request is pending, the new `gnt_o` is registered on the same edge (back-to-back, no idle cycle). Otherwise the FSM goes to `IDLE`.
- Round-robin: search starts at `ptr`. `ptr` is updated to `winner+1` (mod `CHANNELS`) on every grant. The just-finished channel therefore has lowest priority if its `req_i` is still high.
- `req_i[g]` is ignored while `g` is granted. Requesters deassert `req_i` at will after seeing `gnt_o`.
- `data_val_i` of non-granted channels is ignored and never reaches the deserializer.
- Gaps in `data_val_i[g]` during `XFER` are legal; the counter holds.
- `deser_srst_o` is 1 during reset. It drops to 0 on the first `clk_i` edge after `arst_n_i` rises, which flushes any stale deserializer state.

## Timing
- Reset values: `gnt_o = 0`, `busy_o = 0`, `word_ch_o = 0`, `word_ch_val_o = 0`, `abort_o = 0`, `deser_srst_o = 1`. Internally `ptr = 0`, `cnt = 0`, FSM in `IDLE`.
- Request to grant: `req_i` is sampled high at edge N, and `gnt_o` is high after edge N.
- `ser_data_o` and `ser_data_val_o` are combinational from `gnt_o` and the channel inputs, with zero latency.
- `word_ch_val_o` rises after the last-bit edge, in the same cycle the deserializer raises `deser_data_val_o`.
- Simultaneous requests: the highest-priority requester from `ptr` wins.
- Reset asserted mid-word: all state clears immediately and `deser_srst_o` goes to 1. The partial word is lost and no `word_ch_val_o` is produced.

## Configuration
- `DESER_ARB_WATCHDOG_EN` defined: a stall counter runs in `XFER`.
  - It clears on every `data_val_i[g]` cycle and increments otherwise.
  - When it reaches `TIMEOUT_CYCLES` consecutive stalled cycles, the word is aborted. On that edge: `gnt_o <= 0`, `cnt <= 0`, `ptr <= g+1`, FSM to `IDLE`, `abort_o` pulses 1, and `deser_srst_o` pulses 1 for one cycle.
  - No `word_ch_val_o` is produced for an aborted word.
- `DESER_ARB_WATCHDOG_EN` undefined: no stall counter, and `abort_o` is tied 0. A stalled channel holds the grant indefinitely, and `deser_srst_o` is high only during reset.

## Test plan
- Single channel, no gaps: `req_i=4'b0010`, 16 valid bits of `16'hA5C3` → `gnt_o=4'b0010` one cycle after the request. Deserializer emits `16'hA5C3`, with `word_ch_o=1` and `word_ch_val_o` aligned to it. Then `gnt_o=0`.
- All four channels requesting from reset: each sends one word → grants in order 0, 1, 2, 3, back-to-back with no idle cycle. Four `word_ch_val_o` pulses with `word_ch_o` = 0, 1, 2, 3.
- Fairness: ch0 holds `req_i` continuously while ch2 requests once → order is ch0, ch2, ch0, not ch0, ch0.
- Gapped stream plus noise: granted ch1 inserts 5 idle cycles mid-word while ch3 toggles `data_val_i` → the word is still correct, and `ser_data_val_o` never reflects ch3.
- Reset mid-word: deassert `arst_n_i` after 7 bits → outputs go to reset values immediately, and `deser_srst_o=1`. After release, a new full word is correct.
- Watchdog (macro defined, `TIMEOUT_CYCLES=8`): ch2 stalls after 5 bits → after 8 idle cycles, `abort_o` and `deser_srst_o` pulse once, with no `word_ch_val_o`. A pending ch3 is granted next and its word is received correctly.
